// File: rtl/ieeedrv_sd_pkg.sv
// Shared types and constants for the IEEE drive SD block-port arbiter.
package ieeedrv_sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } sd_state_t;

    localparam int LBAW_DEF = 32;
    localparam int BCW_DEF  = 6;
    localparam int GRW      = 3;

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping modulo N.
module ieeedrv_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] index
);

    logic [PW-1:0] pos;

    // Walk N positions starting at ptr; the first set request wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = PW'((32'(ptr) + k) % N);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter funnelling per-device SD block requests onto one host SD port.
module ieeedrv_sd_arb
    import ieeedrv_sd_pkg::*;
#(
    parameter int NBD  = 2,
    parameter int LBAW = LBAW_DEF,
    parameter int BCW  = BCW_DEF
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [NBD*LBAW-1:0] dev_lba,
    input  logic [NBD*BCW-1:0]  dev_blk_cnt,
    input  logic [NBD-1:0]      dev_rd,
    input  logic [NBD-1:0]      dev_wr,
    output logic [NBD-1:0]      dev_ack,
    input  logic [NBD*8-1:0]    dev_buff_din,
    output logic [LBAW-1:0]     host_lba,
    output logic [BCW-1:0]      host_blk_cnt,
    output logic                host_rd,
    output logic                host_wr,
    input  logic                host_ack,
    output logic [7:0]          host_buff_din,
    output logic                busy,
    output logic [GRW-1:0]      grant
);

    localparam int PW = (NBD > 1) ? $clog2(NBD) : 1;

    logic [LBAW-1:0] lba_arr [NBD];
    logic [BCW-1:0]  blk_arr [NBD];
    logic [7:0]      din_arr [NBD];
    logic [NBD-1:0]  req;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;

    sd_state_t       state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   gnt, gnt_n;
    logic [LBAW-1:0] lba_n;
    logic [BCW-1:0]  blk_n;
    logic            rd_n, wr_n, busy_n;
    logic [NBD-1:0]  ack_n;

    for (genvar i = 0; i < NBD; i++) begin : g_unpack
        assign lba_arr[i] = dev_lba[i*LBAW +: LBAW];
        assign blk_arr[i] = dev_blk_cnt[i*BCW +: BCW];
        assign din_arr[i] = dev_buff_din[i*8 +: 8];
    end

    assign req           = dev_rd | dev_wr;
    assign grant         = GRW'(gnt);
    assign host_buff_din = din_arr[gnt];

    ieeedrv_rr_pick #(
        .N  (NBD),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Next-state and next-output decode for the grant/handshake sequence.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt;
        lba_n   = host_lba;
        blk_n   = host_blk_cnt;
        rd_n    = host_rd;
        wr_n    = host_wr;
        ack_n   = dev_ack;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n   = pick_idx;
                    lba_n   = lba_arr[pick_idx];
                    blk_n   = blk_arr[pick_idx];
                    busy_n  = 1'b1;
                    wr_n    = dev_wr[pick_idx];
                    rd_n    = ~dev_wr[pick_idx];
                    state_n = REQ;
                end
            end
            REQ: begin
                // host_ack is tested first so it beats a simultaneous request drop
                if (host_ack) begin
                    rd_n       = 1'b0;
                    wr_n       = 1'b0;
                    ack_n      = '0;
                    ack_n[gnt] = 1'b1;
                    state_n    = XFER;
                end else if (!req[gnt]) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = DONE;
                end
            end
            XFER: begin
                ack_n      = '0;
                ack_n[gnt] = host_ack;
                if (!host_ack) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                ptr_n   = (gnt == PW'(NBD - 1)) ? '0 : gnt + PW'(1);
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything without a clock.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            host_lba     <= '0;
            host_blk_cnt <= '0;
            host_rd      <= 1'b0;
            host_wr      <= 1'b0;
            dev_ack      <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            gnt          <= gnt_n;
            host_lba     <= lba_n;
            host_blk_cnt <= blk_n;
            host_rd      <= rd_n;
            host_wr      <= wr_n;
            dev_ack      <= ack_n;
            busy         <= busy_n;
        end
    end

endmodule
